router_input_port: RTL and testbench

ROUTER_INPUT_PORT -- requirements
Module: router_input_port

---
 rtl/noc_pkg.sv | 9 +
 rtl/flit_fifo.sv | 52 +++++
 rtl/router_input_port.sv | 57 +++++
 tb/tb_router_input_port.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router parameters and flit type.
package noc_pkg;
   localparam int unsigned FLIT_W    = 20;
   localparam int unsigned BUF_DEPTH = 4;
   localparam int unsigned PTR_W     = 2;
   localparam int unsigned CNT_W     = PTR_W + 1;

   typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/flit_fifo.sv
// 4-entry flit FIFO: storage, wrapping 2-bit pointers and 0..4 occupancy counter.
module flit_fifo
   import noc_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  flit_t wr_data,
   input  logic  wr_req,
   input  logic  rd_req,
   output flit_t rd_data,
   output logic  not_empty,
   output logic  full,
   output logic  rd_en
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   flit_t            mem [BUF_DEPTH];
   logic             wr_en;

   assign full      = (count == CNT_W'(BUF_DEPTH));
   assign not_empty = (count != '0);
   // A full FIFO refuses the write even if a read frees a slot on the same edge.
   assign wr_en     = wr_req && !full;
   assign rd_en     = rd_req && not_empty;
   assign rd_data   = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/router_input_port.sv
// Router input port: credit-based 4-flit buffer with one-cycle credit return.
// Optional sticky overflow flag ovf_err enabled by ROUTER_OVF_CHECK_EN.
module router_input_port
   import noc_pkg::*;
(
   input  logic              clk,
   input  logic              RST,
   input  logic [FLIT_W-1:0] datain,
   input  logic              in_valid,
   output logic              co,
   output logic [FLIT_W-1:0] dataout,
   output logic              out_valid,
   input  logic              out_ready
`ifdef ROUTER_OVF_CHECK_EN
   ,
   output logic              ovf_err
`endif
);

   logic rd_en;
`ifdef ROUTER_OVF_CHECK_EN
   logic full;
`endif

   flit_fifo u_fifo (
      .clk       (clk),
      .rst_n     (RST),
      .wr_data   (datain),
      .wr_req    (in_valid),
      .rd_req    (out_ready),
      .rd_data   (dataout),
      .not_empty (out_valid),
`ifdef ROUTER_OVF_CHECK_EN
      .full      (full),
`else
      .full      (),
`endif
      .rd_en     (rd_en)
   );

   always_ff @(posedge clk or negedge RST) begin
      if (!RST)
         co <= 1'b0;
      else
         co <= rd_en;
   end

`ifdef ROUTER_OVF_CHECK_EN
   always_ff @(posedge clk or negedge RST) begin
      if (!RST)
         ovf_err <= 1'b0;
      else if (in_valid && full)
         ovf_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port; ovf_err checks compiled in with ROUTER_OVF_CHECK_EN.
module tb_router_input_port;

   logic        clk = 1'b0;
   logic        RST = 1'b0;
   logic [19:0] datain = '0;
   logic        in_valid = 1'b0;
   logic        co;
   logic [19:0] dataout;
   logic        out_valid;
   logic        out_ready = 1'b0;
`ifdef ROUTER_OVF_CHECK_EN
   logic        ovf_err;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   router_input_port dut (
      .clk       (clk),
      .RST       (RST),
      .datain    (datain),
      .in_valid  (in_valid),
      .co        (co),
      .dataout   (dataout),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ROUTER_OVF_CHECK_EN
      ,
      .ovf_err   (ovf_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance through one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [19:0] v);
      datain   = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   logic [19:0] sb [$];
   logic        prev_deq;
   int          credits;
   int unsigned seq;
   logic        deq;
   logic        snd;

   initial begin
      // Reset state
      tick();
      check("rst_ov", 32'(out_valid), 0);
      check("rst_co", 32'(co), 0);
      check("rst_do", 32'(dataout), 0);
`ifdef ROUTER_OVF_CHECK_EN
      check("rst_ovf", 32'(ovf_err), 0);
`endif
      tick();
      RST = 1'b1;

      // Single write with out_ready low
      push(20'hABCDE);
      check("t1_ov", 32'(out_valid), 1);
      check("t1_do", 32'(dataout), 32'hABCDE);
      check("t1_co", 32'(co), 0);
      tick();
      check("t1_co_hold", 32'(co), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_co_pulse", 32'(co), 1);
      check("t1_empty", 32'(out_valid), 0);
      tick();
      check("t1_co_end", 32'(co), 0);

      // Fill 1..4, stall, then drain with consecutive credits
      for (int i = 1; i <= 4; i++) push(20'(i));
      check("t2_head", 32'(dataout), 1);
      tick();
      check("t2_stable", 32'(dataout), 1);
      check("t2_co_idle", 32'(co), 0);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("t2_order", 32'(dataout), 32'(k));
         tick();
         check("t2_co", 32'(co), 1);
      end
      out_ready = 1'b0;
      check("t2_empty", 32'(out_valid), 0);
      tick();
      check("t2_co_end", 32'(co), 0);

      // Full FIFO: incoming flit dropped despite same-edge dequeue
      for (int i = 0; i < 4; i++) push(20'h10 + 20'(i));
      datain    = 20'hFFFFF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t3_co", 32'(co), 1);
`ifdef ROUTER_OVF_CHECK_EN
      check("t3_ovf", 32'(ovf_err), 1);
`endif
      for (int k = 1; k <= 3; k++) begin
         check("t3_order", 32'(dataout), 32'h10 + 32'(k));
         tick();
      end
      out_ready = 1'b0;
      check("t3_no_drop_flit", 32'(out_valid), 0);
`ifdef ROUTER_OVF_CHECK_EN
      tick();
      check("t3_ovf_sticky", 32'(ovf_err), 1);
`endif

      // Occupancy 2 with simultaneous write and dequeue for 10 cycles
      push(20'h100);
      push(20'h101);
      tick();
      for (int i = 0; i < 10; i++) begin
         datain    = 20'h102 + 20'(i);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         check("t4_order", 32'(dataout), 32'h100 + 32'(i));
         tick();
         check("t4_co", 32'(co), 1);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("t4_tail", 32'(dataout), 32'h10A + 32'(i));
         tick();
      end
      out_ready = 1'b0;
      check("t4_occ2", 32'(out_valid), 0);
      tick();

      // Reset mid-operation with 3 flits buffered
      for (int i = 0; i < 3; i++) push(20'h200 + 20'(i));
      RST = 1'b0;
      #1;
      check("t5_ov", 32'(out_valid), 0);
      check("t5_co", 32'(co), 0);
      check("t5_do", 32'(dataout), 0);
`ifdef ROUTER_OVF_CHECK_EN
      check("t5_ovf", 32'(ovf_err), 0);
`endif
      tick();
      tick();
      RST = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_no_co", 32'(co), 0);
         check("t5_no_ov", 32'(out_valid), 0);
      end
      out_ready = 1'b0;
      push(20'h300);
      check("t5_resume", 32'(dataout), 32'h300);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      // Credit-paced sender (PE 13) vs random out_ready
      credits  = 4;
      prev_deq = 1'b0;
      seq      = 0;
      for (int c = 0; c < 200; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         check("t6_ov", 32'(out_valid), 32'(sb.size() != 0));
         check("t6_co", 32'(co), 32'(prev_deq));
         deq = (sb.size() != 0) && out_ready;
         if (deq) check("t6_data", 32'(dataout), 32'(sb[0]));
         snd = (credits > 0) && ($urandom_range(0, 3) != 0);
         in_valid = snd;
         datain   = {4'hD, 16'(seq)};
         tick();
         if (deq) void'(sb.pop_front());
         if (snd) begin
            sb.push_back({4'hD, 16'(seq)});
            seq++;
            credits--;
         end
         if (prev_deq) credits++;
         prev_deq = deq;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() != 0; c++) begin
         check("t6_drain", 32'(dataout), 32'(sb[0]));
         void'(sb.pop_front());
         tick();
      end
      out_ready = 1'b0;
      check("t6_all_rx", 32'(sb.size()), 0);
      check("t6_empty", 32'(out_valid), 0);
`ifdef ROUTER_OVF_CHECK_EN
      check("t6_ovf", 32'(ovf_err), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
